ss_mem_arbiter: RTL and testbench
=================================

Name: ss_mem_arbiter

Overview:
- Controller that backs the data stack (DS) and return stack (RS) with one shared single-port 32-bit memory block (mb32-style master signals).
- Each stack caches its TOS in a register. Deeper entries live in the RAM at separate base addresses.
- Accepts sop_e requests from two requesters over a req/ack handshake, arbitrates round-robin, and sequences the RAM write/read cycles.
- Sits between the ForthSuper core's stack-op decode and the stack RAM.

Parameters:
- DEPTH, 64, RAM entries per stack (power of 2).
- DSZ, 32, data width.
- ASZ, 15, RAM address width.
- DS_BASE, 0, RAM word address of DS entry 0.
- RS_BASE, 64, RAM word address of RS entry 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ds_req  in  1  DS request; held until ds_ack.
- ds_op  in  2  sop_e: LOAD/PUSH/POP/PICK.
- ds_vi  in  DSZ  push/load value, or pick index (low $clog2(DEPTH) bits).
- ds_ack  out  1  one-cycle completion pulse.
- ds_err  out  1  valid with ds_ack; op rejected.
- ds_tos  out  DSZ  cached top of DS.
- ds_sp  out  $clog2(DEPTH)+1  DS entries held in RAM (0..DEPTH).
- rs_req, rs_op, rs_vi, rs_ack, rs_err, rs_tos, rs_sp: same as the DS ports, for RS.
- mem_we  out  1  RAM write enable.
- mem_bmsk  out  4  byte mask; 4'hF whenever mem_we=1, else 0.
- mem_ai  out  ASZ  RAM word address.
- mem_vi  out  DSZ  RAM write data.
- mem_vo  in  DSZ  RAM read data; valid 1 cycle after mem_ai is presented with mem_we=0.

Behaviour:
- Reset: state=IDLE, *_sp=0, *_tos=all ones, *_ack=0, *_err=0, mem_we=0, mem_bmsk=0, mem_ai=0, mem_vi=0, last-grant=RS.
- Reset while busy: the in-flight op is aborted; no ack is issued and the RAM is not written.
- Memory outputs are combinational from state and latched op. mem_we is forced 0 whenever rst=1.
- FSM states: IDLE, EXEC, WAIT.
- IDLE:
  - A requester is eligible if req=1 and its ack is not asserted this cycle (this blocks re-grant of a held req).
  - One eligible requester is granted. If both are eligible, the one not granted last wins.
  - Latch owner, op and vi; go to EXEC.
- EXEC, for owner stack with base B, sp, tos:
  - LOAD: no RAM access; tos<=vi; ack; go to IDLE.
  - PUSH with sp<DEPTH: mem_we=1, mem_ai=B+sp, mem_vi=tos; tos<=vi; sp<=sp+1; ack; go to IDLE.
  - POP with sp>0: mem_ai=B+sp-1, we=0; go to WAIT.
  - PICK with idx<sp: mem_ai=B+sp-1-idx, we=0; go to WAIT.
  - Error cases: PUSH with sp==DEPTH, POP with sp==0, PICK with idx>=sp. No RAM access; tos and sp unchanged; ack and err both set; go to IDLE.
- WAIT: tos<=mem_vo. For POP only, sp<=sp-1. Ack; go to IDLE.
- ack/err are registered and high in the cycle after EXEC completes (LOAD, PUSH, error) or after WAIT (POP, PICK).
- Latency from req sampled in IDLE to ack: 2 cycles for LOAD/PUSH/error; 3 cycles for POP/PICK.
- Throughput: at most one RAM access per cycle. The other requester waits in req and is never dropped.
- Address arithmetic is done at ASZ bits. B+sp never exceeds B+DEPTH-1 on an access.
- The ops of one stack are fully serialized. A new req is accepted only after the previous ack.

Decomposition:
- Shared package holds:
  - sop_e (existing);
  - state enum arb_st_e {IDLE, EXEC, WAIT};
  - grant enum own_e {OWN_DS, OWN_RS};
  - localparam SSZ=$clog2(DEPTH).
- Natural sub-module ss_cache:
  - one instance per stack;
  - holds tos/sp registers, computes the error check and the read/write address offset;
  - applies updates on strobes from the arbiter FSM.

Test Plan:
- Reset, then DS PUSH 0x11 -> EXEC write ai=0, vi=FFFFFFFF, bmsk=F; ds_ack 2 cycles after req; ds_tos=0x11, ds_sp=1, ds_err=0.
- Then DS PUSH 0x22, then DS POP -> push writes ai=1, vi=0x11; pop reads ai=1, ack 3 cycles after req; ds_tos=0x11, ds_sp=1.
- From reset, DS and RS PUSH asserted the same cycle -> DS granted first (ai=0), RS next (ai=64, vi=FFFFFFFF); acks in distinct cycles.
  - Both then held continuously -> grants alternate RS, DS, RS.
- RS POP with rs_sp=0 -> rs_ack with rs_err=1; mem_we=0; no read issued; rs_tos unchanged; rs_sp=0.
- DS pushes 1,2,3 from reset, then PICK vi=1 -> read ai=1; ds_tos=1; ds_sp stays 3.
  - PICK vi=3 -> err; no read.
- DS filled to sp=64, PUSH 0x5 -> err; sp=64; no write.
  - Then a POP is issued and rst is asserted in its WAIT -> no ack; ds_sp=0; ds_tos=FFFFFFFF next cycle.

Source files
------------

// File: rtl/ss_mem_arbiter_pkg.sv
// Shared types for the stack-cache memory arbiter.
// Holds stack-op, FSM state and grant-owner enums.
package ss_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SOP_LOAD,
    SOP_PUSH,
    SOP_POP,
    SOP_PICK
  } sop_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT
  } arb_st_e;

  typedef enum logic {
    OWN_DS,
    OWN_RS
  } own_e;

  localparam int STK_DEPTH = 64;
  localparam int SSZ       = $clog2(STK_DEPTH);

endpackage

// File: rtl/ss_mem_arbiter_cache.sv
// Per-stack TOS/SP cache: holds tos and sp, flags illegal ops, makes RAM address.
// Ports: clk/rst, op+idx, update strobes, vi/rd data; outputs tos, sp, err, addr.
module ss_mem_arbiter_cache
  import ss_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int ASZ   = 15,
  parameter int BASE  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  sop_e                     op,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic                     ld_vi,
  input  logic                     ld_rd,
  input  logic                     inc_sp,
  input  logic                     dec_sp,
  input  logic [DSZ-1:0]           vi,
  input  logic [DSZ-1:0]           rd,
  output logic [DSZ-1:0]           tos,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     err,
  output logic [ASZ-1:0]           addr
);

  localparam int IW = $clog2(DEPTH);

  logic [DSZ-1:0] tos_q, tos_d;
  logic [IW:0]    sp_q, sp_d;
  logic [IW:0]    idx_ext;
  logic [ASZ-1:0] base_a, sp_a, idx_a;

  assign idx_ext = {1'b0, idx};
  assign base_a  = ASZ'(BASE);
  assign sp_a    = ASZ'(sp_q);
  assign idx_a   = ASZ'(idx);

  always_comb begin
    tos_d = tos_q;
    sp_d  = sp_q;
    if (ld_vi) tos_d = vi;
    if (ld_rd) tos_d = rd;
    if (inc_sp) sp_d = sp_q + 1'b1;
    if (dec_sp) sp_d = sp_q - 1'b1;
  end

  always_comb begin
    err  = 1'b0;
    addr = base_a;
    unique case (1'b1)
      (op == SOP_PUSH): begin
        err  = (sp_q == (IW+1)'(DEPTH));
        addr = base_a + sp_a;
      end
      (op == SOP_POP): begin
        err  = (sp_q == '0);
        addr = base_a + sp_a - 1'b1;
      end
      (op == SOP_PICK): begin
        err  = (idx_ext >= sp_q);
        addr = base_a + sp_a - 1'b1 - idx_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q <= '1;
      sp_q  <= '0;
    end else begin
      tos_q <= tos_d;
      sp_q  <= sp_d;
    end
  end

  assign tos = tos_q;
  assign sp  = sp_q;

endmodule

// File: rtl/ss_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between DS and RS caches.
// Ports: ds_*/rs_* req/ack stack-op channels, mem_* RAM master signals.
module ss_mem_arbiter
  import ss_mem_arbiter_pkg::*;
#(
  parameter int DEPTH   = STK_DEPTH,
  parameter int DSZ     = 32,
  parameter int ASZ     = 15,
  parameter int DS_BASE = 0,
  parameter int RS_BASE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ds_req,
  input  logic [1:0]             ds_op,
  input  logic [DSZ-1:0]         ds_vi,
  output logic                   ds_ack,
  output logic                   ds_err,
  output logic [DSZ-1:0]         ds_tos,
  output logic [$clog2(DEPTH):0] ds_sp,
  input  logic                   rs_req,
  input  logic [1:0]             rs_op,
  input  logic [DSZ-1:0]         rs_vi,
  output logic                   rs_ack,
  output logic                   rs_err,
  output logic [DSZ-1:0]         rs_tos,
  output logic [$clog2(DEPTH):0] rs_sp,
  output logic                   mem_we,
  output logic [3:0]             mem_bmsk,
  output logic [ASZ-1:0]         mem_ai,
  output logic [DSZ-1:0]         mem_vi,
  input  logic [DSZ-1:0]         mem_vo
);

  localparam int IW = $clog2(DEPTH);

  arb_st_e        state_q, state_d;
  own_e           own_q, own_d;
  own_e           last_q, last_d;
  sop_e           op_q, op_d;
  logic [DSZ-1:0] vi_q, vi_d;
  logic           ds_ack_q, ds_ack_d;
  logic           ds_err_q, ds_err_d;
  logic           rs_ack_q, rs_ack_d;
  logic           rs_err_q, rs_err_d;

  logic ds_elig, rs_elig, grant_rs;
  logic ack, nak;
  logic ld_vi, ld_rd, inc_sp, dec_sp;
  logic we_c;
  logic is_ds, is_rs;

  logic           ds_c_err, rs_c_err, cur_err;
  logic [ASZ-1:0] ds_c_addr, rs_c_addr, cur_addr;
  logic [DSZ-1:0] cur_tos;

  assign is_ds = (own_q == OWN_DS);
  assign is_rs = (own_q == OWN_RS);

  assign cur_err  = is_ds ? ds_c_err  : rs_c_err;
  assign cur_addr = is_ds ? ds_c_addr : rs_c_addr;
  assign cur_tos  = is_ds ? ds_tos    : rs_tos;

  // A held req must not be re-granted in its own ack cycle.
  assign ds_elig = ds_req & ~ds_ack_q;
  assign rs_elig = rs_req & ~rs_ack_q;

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    op_d     = op_q;
    vi_d     = vi_q;
    grant_rs = 1'b0;
    ack      = 1'b0;
    nak      = 1'b0;
    ld_vi    = 1'b0;
    ld_rd    = 1'b0;
    inc_sp   = 1'b0;
    dec_sp   = 1'b0;
    we_c     = 1'b0;
    mem_ai   = '0;
    mem_vi   = '0;
    unique case (state_q)
      IDLE: begin
        if (ds_elig | rs_elig) begin
          grant_rs = rs_elig & (~ds_elig | (last_q == OWN_DS));
          own_d    = grant_rs ? OWN_RS : OWN_DS;
          last_d   = own_d;
          op_d     = grant_rs ? sop_e'(rs_op) : sop_e'(ds_op);
          vi_d     = grant_rs ? rs_vi : ds_vi;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cur_err) begin
          ack     = 1'b1;
          nak     = 1'b1;
          state_d = IDLE;
        end else begin
          unique case (op_q)
            SOP_LOAD: begin
              ld_vi   = 1'b1;
              ack     = 1'b1;
              state_d = IDLE;
            end
            SOP_PUSH: begin
              we_c    = 1'b1;
              mem_ai  = cur_addr;
              mem_vi  = cur_tos;
              ld_vi   = 1'b1;
              inc_sp  = 1'b1;
              ack     = 1'b1;
              state_d = IDLE;
            end
            SOP_POP, SOP_PICK: begin
              mem_ai  = cur_addr;
              state_d = WAIT;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      WAIT: begin
        ld_rd   = 1'b1;
        dec_sp  = (op_q == SOP_POP);
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ds_ack_d = ack & is_ds;
    ds_err_d = nak & is_ds;
    rs_ack_d = ack & is_rs;
    rs_err_d = nak & is_rs;
  end

  assign mem_we   = we_c & ~rst;
  assign mem_bmsk = {4{mem_we}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      own_q    <= OWN_DS;
      last_q   <= OWN_RS;
      op_q     <= SOP_LOAD;
      vi_q     <= '0;
      ds_ack_q <= 1'b0;
      ds_err_q <= 1'b0;
      rs_ack_q <= 1'b0;
      rs_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      op_q     <= op_d;
      vi_q     <= vi_d;
      ds_ack_q <= ds_ack_d;
      ds_err_q <= ds_err_d;
      rs_ack_q <= rs_ack_d;
      rs_err_q <= rs_err_d;
    end
  end

  assign ds_ack = ds_ack_q;
  assign ds_err = ds_err_q;
  assign rs_ack = rs_ack_q;
  assign rs_err = rs_err_q;

  ss_mem_arbiter_cache #(
    .DEPTH(DEPTH), .DSZ(DSZ), .ASZ(ASZ), .BASE(DS_BASE)
  ) u_ds (
    .clk   (clk),
    .rst   (rst),
    .op    (op_q),
    .idx   (vi_q[IW-1:0]),
    .ld_vi (ld_vi & is_ds),
    .ld_rd (ld_rd & is_ds),
    .inc_sp(inc_sp & is_ds),
    .dec_sp(dec_sp & is_ds),
    .vi    (vi_q),
    .rd    (mem_vo),
    .tos   (ds_tos),
    .sp    (ds_sp),
    .err   (ds_c_err),
    .addr  (ds_c_addr)
  );

  ss_mem_arbiter_cache #(
    .DEPTH(DEPTH), .DSZ(DSZ), .ASZ(ASZ), .BASE(RS_BASE)
  ) u_rs (
    .clk   (clk),
    .rst   (rst),
    .op    (op_q),
    .idx   (vi_q[IW-1:0]),
    .ld_vi (ld_vi & is_rs),
    .ld_rd (ld_rd & is_rs),
    .inc_sp(inc_sp & is_rs),
    .dec_sp(dec_sp & is_rs),
    .vi    (vi_q),
    .rd    (mem_vo),
    .tos   (rs_tos),
    .sp    (rs_sp),
    .err   (rs_c_err),
    .addr  (rs_c_addr)
  );

endmodule

// File: tb/tb_ss_mem_arbiter.sv
// Testbench for ss_mem_arbiter: directed steps plus random ops vs a stack model.
// Drives both requesters, models the RAM, checks acks, errs, tos, sp and RAM use.
module tb_ss_mem_arbiter;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;
  localparam int ASZ   = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ds_req = 1'b0, rs_req = 1'b0;
  logic [1:0]     ds_op = '0, rs_op = '0;
  logic [DSZ-1:0] ds_vi = '0, rs_vi = '0;
  logic           ds_ack, ds_err, rs_ack, rs_err;
  logic [DSZ-1:0] ds_tos, rs_tos;
  logic [6:0]     ds_sp, rs_sp;
  logic           mem_we;
  logic [3:0]     mem_bmsk;
  logic [ASZ-1:0] mem_ai;
  logic [DSZ-1:0] mem_vi;
  logic [DSZ-1:0] mem_vo = '0;

  logic [DSZ-1:0] ram [0:127];

  int checks = 0;
  int errors = 0;

  logic [DSZ-1:0] mtos [2];
  logic [DSZ-1:0] mq   [2][$];

  ss_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ds_req(ds_req), .ds_op(ds_op), .ds_vi(ds_vi),
    .ds_ack(ds_ack), .ds_err(ds_err), .ds_tos(ds_tos), .ds_sp(ds_sp),
    .rs_req(rs_req), .rs_op(rs_op), .rs_vi(rs_vi),
    .rs_ack(rs_ack), .rs_err(rs_err), .rs_tos(rs_tos), .rs_sp(rs_sp),
    .mem_we(mem_we), .mem_bmsk(mem_bmsk), .mem_ai(mem_ai),
    .mem_vi(mem_vi), .mem_vo(mem_vo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_ai[6:0]] <= mem_vi;
    mem_vo <= ram[mem_ai[6:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int base(input int s);
    return (s == 0) ? 0 : 64;
  endfunction

  function automatic logic ack_of(input int s);
    return (s == 0) ? ds_ack : rs_ack;
  endfunction

  function automatic logic err_of(input int s);
    return (s == 0) ? ds_err : rs_err;
  endfunction

  function automatic logic [DSZ-1:0] tos_of(input int s);
    return (s == 0) ? ds_tos : rs_tos;
  endfunction

  function automatic logic [6:0] sp_of(input int s);
    return (s == 0) ? ds_sp : rs_sp;
  endfunction

  task automatic mreset();
    for (int s = 0; s < 2; s++) begin
      mtos[s] = '1;
      mq[s].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ds_req = 1'b0;
    rs_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mreset();
  endtask

  // Issue one op on one stack and check it against the model.
  task automatic do_op(input int s, input logic [1:0] op,
                       input logic [DSZ-1:0] v, input string tag);
    int n, idx, lat, cyc;
    bit e, got, rd;
    logic           exp_we;
    int             exp_ai;
    logic [DSZ-1:0] exp_vi, nt;
    n      = mq[s].size();
    idx    = int'(v[5:0]);
    e      = 1'b0;
    rd     = 1'b0;
    exp_we = 1'b0;
    exp_ai = 0;
    exp_vi = '0;
    nt     = mtos[s];
    case (op)
      2'd0: nt = v;
      2'd1: begin
        e = (n == DEPTH);
        if (!e) begin
          exp_we = 1'b1;
          exp_ai = base(s) + n;
          exp_vi = mtos[s];
          nt     = v;
        end
      end
      2'd2: begin
        e = (n == 0);
        if (!e) begin
          rd     = 1'b1;
          exp_ai = base(s) + n - 1;
          nt     = mq[s][n-1];
        end
      end
      default: begin
        e = (idx >= n);
        if (!e) begin
          rd     = 1'b1;
          exp_ai = base(s) + n - 1 - idx;
          nt     = mq[s][n-1-idx];
        end
      end
    endcase
    lat = rd ? 3 : 2;
    @(negedge clk);
    if (s == 0) begin
      ds_req = 1'b1; ds_op = op; ds_vi = v;
    end else begin
      rs_req = 1'b1; rs_op = op; rs_vi = v;
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({tag, ".we"}, mem_we, exp_we);
        chk({tag, ".bmsk"}, mem_bmsk, exp_we ? 4'hF : 4'h0);
        if (exp_we || rd) chk({tag, ".ai"}, mem_ai, exp_ai);
        if (exp_we) chk({tag, ".vi"}, mem_vi, exp_vi);
      end
      if (ack_of(s)) got = 1'b1;
    end
    ds_req = 1'b0;
    rs_req = 1'b0;
    chk({tag, ".ack"}, got, 1'b1);
    chk({tag, ".lat"}, cyc, lat);
    chk({tag, ".err"}, err_of(s), e);
    if (!e) begin
      case (op)
        2'd1: mq[s].push_back(mtos[s]);
        2'd2: void'(mq[s].pop_back());
        default: ;
      endcase
      mtos[s] = nt;
    end
    chk({tag, ".tos"}, tos_of(s), mtos[s]);
    chk({tag, ".sp"}, sp_of(s), mq[s].size());
  endtask

  initial begin
    int own_exp [4];
    int nw, nack, s, op, n;
    logic [DSZ-1:0] v;

    mreset();
    do_reset();

    chk("rst.ds_sp", ds_sp, 0);
    chk("rst.rs_sp", rs_sp, 0);
    chk("rst.ds_tos", ds_tos, 32'hFFFF_FFFF);
    chk("rst.rs_tos", rs_tos, 32'hFFFF_FFFF);
    chk("rst.acks", {ds_ack, ds_err, rs_ack, rs_err}, 4'h0);
    chk("rst.mem", {mem_we, mem_bmsk, mem_ai, mem_vi}, '0);

    do_op(0, 2'd1, 32'h11, "push11");
    do_op(0, 2'd1, 32'h22, "push22");
    do_op(0, 2'd2, 32'h0, "pop");

    // Simultaneous requests, both held: grants alternate DS, RS, DS, RS.
    do_reset();
    own_exp = '{0, 1, 0, 1};
    @(negedge clk);
    ds_req = 1'b1; ds_op = 2'd1; ds_vi = 32'hA;
    rs_req = 1'b1; rs_op = 2'd1; rs_vi = 32'hB;
    nw = 0;
    nack = 0;
    for (int c = 0; c < 20 && nack < 4; c++) begin
      @(negedge clk);
      if (mem_we && nw < 4) begin
        s = own_exp[nw];
        chk("rr.ai", mem_ai, base(s) + mq[s].size());
        chk("rr.vi", mem_vi, mtos[s]);
        mq[s].push_back(mtos[s]);
        mtos[s] = (s == 0) ? 32'hA : 32'hB;
        nw++;
      end
      if (ds_ack || rs_ack) begin
        chk("rr.excl", ds_ack & rs_ack, 1'b0);
        chk("rr.owner", rs_ack, own_exp[nack] == 1);
        nack++;
        if (nack == 4) begin
          ds_req = 1'b0;
          rs_req = 1'b0;
        end
      end
    end
    ds_req = 1'b0;
    rs_req = 1'b0;
    chk("rr.nack", nack, 4);
    chk("rr.nw", nw, 4);
    chk("rr.ds_tos", ds_tos, mtos[0]);
    chk("rr.rs_tos", rs_tos, mtos[1]);
    chk("rr.ds_sp", ds_sp, mq[0].size());
    chk("rr.rs_sp", rs_sp, mq[1].size());

    do_reset();
    do_op(1, 2'd2, 32'h0, "rs_pop_empty");

    do_reset();
    do_op(0, 2'd1, 32'h1, "p1");
    do_op(0, 2'd1, 32'h2, "p2");
    do_op(0, 2'd1, 32'h3, "p3");
    do_op(0, 2'd3, 32'h1, "pick1");
    do_op(0, 2'd3, 32'h3, "pick3");
    do_op(0, 2'd0, 32'h77, "load");

    // Fill DS, overflow, then reset in the WAIT state of a POP.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(0, 2'd1, i + 100, "fill");
    do_op(0, 2'd1, 32'h5, "push_full");
    @(negedge clk);
    ds_req = 1'b1; ds_op = 2'd2; ds_vi = '0;
    @(negedge clk);
    chk("abort.exec_we", mem_we, 1'b0);
    chk("abort.exec_ai", mem_ai, DEPTH - 1);
    @(negedge clk);
    chk("abort.wait_ack", ds_ack, 1'b0);
    rst = 1'b1;
    ds_req = 1'b0;
    #1;
    chk("abort.rst_we", mem_we, 1'b0);
    @(negedge clk);
    chk("abort.ack", ds_ack, 1'b0);
    chk("abort.sp", ds_sp, 0);
    chk("abort.tos", ds_tos, 32'hFFFF_FFFF);
    rst = 1'b0;
    mreset();

    for (int i = 0; i < 300; i++) begin
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      n  = mq[s].size();
      if (op == 3) v = $urandom_range(0, n + 1);
      else v = $urandom;
      do_op(s, op[1:0], v, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
